// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one carry-lookahead adder among
// R add/subtract requesters, with a single registered valid/ready result stage.
// Optional build macro ADD_SHARE_SAT_EN clamps overflowed results to the
// signed extreme instead of wrapping.

// Block carry-lookahead adder: block generate/propagate chain, ripple inside a block
module carryLookAhead #(
  parameter int unsigned N     = 32,
  parameter int unsigned BLOCK = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  localparam int unsigned NB = (N + BLOCK - 1) / BLOCK;

  logic [N-1:0]  g, p, c;
  logic [NB-1:0] bg, bp;
  logic [NB:0]   bc;
  logic          carry;

  // Block-level lookahead carries, then per-bit carries inside each block
  always_comb begin
    g     = a & b;
    p     = a ^ b;
    bg    = '0;
    bp    = '1;
    bc    = '0;
    c     = '0;
    carry = 1'b0;
    bc[0] = cin;
    for (int unsigned k = 0; k < NB; k++) begin
      for (int unsigned j = 0; j < BLOCK; j++) begin
        if (k * BLOCK + j < N) begin
          bg[k] = g[k*BLOCK+j] | (p[k*BLOCK+j] & bg[k]);
          bp[k] = bp[k] & p[k*BLOCK+j];
        end
      end
      bc[k+1] = bg[k] | (bp[k] & bc[k]);
    end
    for (int unsigned k = 0; k < NB; k++) begin
      carry = bc[k];
      for (int unsigned j = 0; j < BLOCK; j++) begin
        if (k * BLOCK + j < N) begin
          c[k*BLOCK+j] = carry;
          carry = g[k*BLOCK+j] | (p[k*BLOCK+j] & carry);
        end
      end
    end
    sum  = p ^ c;
    cout = bc[NB];
  end
endmodule

module adder_share_arbiter #(
  parameter int unsigned N     = 32,
  parameter int unsigned BLOCK = 4,
  parameter int unsigned R     = 4,
  parameter int unsigned IDW   = (R > 1) ? $clog2(R) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [R-1:0]     req_valid,
  output logic [R-1:0]     req_ready,
  input  logic [R*N-1:0]   req_a,
  input  logic [R*N-1:0]   req_b,
  input  logic [R-1:0]     req_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic [IDW-1:0]   rsp_id
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] ptr_after;
  logic [R-1:0]   ready_c;
  logic           found, can_accept, transfer;
  logic [N-1:0]   a_sel, b_sel, b_eff, sum_raw, sum_fin;
  logic           sub_sel, cout_raw, ovf;

  // Round-robin search from ptr; also muxes the winner's operands
  always_comb begin
    found     = 1'b0;
    grant     = '0;
    ptr_after = '0;
    a_sel     = '0;
    b_sel     = '0;
    sub_sel   = 1'b0;
    ready_c   = '0;
    for (int unsigned off = 0; off < R; off++) begin
      int unsigned idx;
      idx = (32'(ptr_q) + off) % R;
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        grant     = IDW'(idx);
        ptr_after = IDW'((idx + 1) % R);
        a_sel     = req_a[idx*N +: N];
        b_sel     = req_b[idx*N +: N];
        sub_sel   = req_sub[idx];
      end
    end
    can_accept = (state_q == EMPTY) || rsp_ready;
    if (found && can_accept && !rst) begin
      ready_c[grant] = 1'b1;
    end
    transfer = |(req_valid & ready_c);
  end

  assign req_ready = ready_c;

  // Subtract is a + ~b + 1 through the shared adder
  assign b_eff = sub_sel ? ~b_sel : b_sel;

  carryLookAhead #(.N(N), .BLOCK(BLOCK)) u_cla (
    .a    (a_sel),
    .b    (b_eff),
    .cin  (sub_sel),
    .sum  (sum_raw),
    .cout (cout_raw)
  );

  assign ovf = (a_sel[N-1] == b_eff[N-1]) && (sum_raw[N-1] != a_sel[N-1]);

`ifdef ADD_SHARE_SAT_EN
  // Clamp to the signed extreme matching the sign of the true result
  always_comb begin
    sum_fin = sum_raw;
    if (ovf) begin
      sum_fin = a_sel[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  end
`else
  assign sum_fin = sum_raw;
`endif

  // Output stage next state and pointer advance
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (transfer) begin
      state_d = FULL;
      ptr_d   = ptr_after;
    end else if (state_q == FULL && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  // State and round-robin pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Result payload register; holds its value once drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_ovf  <= 1'b0;
      rsp_id   <= '0;
    end else if (transfer) begin
      rsp_sum  <= sum_fin;
      rsp_cout <= cout_raw;
      rsp_ovf  <= ovf;
      rsp_id   <= grant;
    end
  end

  assign rsp_valid = (state_q == FULL);
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter (N=32, R=4).
module tb_adder_share_arbiter;
  localparam int unsigned N   = 32;
  localparam int unsigned R   = 4;
  localparam int unsigned IDW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [R-1:0]    req_valid;
  logic [R-1:0]    req_ready;
  logic [R*N-1:0]  req_a;
  logic [R*N-1:0]  req_b;
  logic [R-1:0]    req_sub;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [N-1:0]    rsp_sum;
  logic            rsp_cout;
  logic            rsp_ovf;
  logic [IDW-1:0]  rsp_id;

  int tests = 0;
  int fails = 0;

  adder_share_arbiter #(.N(N), .BLOCK(4), .R(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic [N-1:0] sum, input logic cout,
                         input logic ovf, input logic [IDW-1:0] id);
    chk({tag, ".valid"}, 64'(rsp_valid), 64'(1));
    chk({tag, ".sum"},   64'(rsp_sum),   64'(sum));
    chk({tag, ".cout"},  64'(rsp_cout),  64'(cout));
    chk({tag, ".ovf"},   64'(rsp_ovf),   64'(ovf));
    chk({tag, ".id"},    64'(rsp_id),    64'(id));
  endtask

  task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
    req_sub[i]      = sub;
  endtask

  logic [IDW-1:0] fair_ids [8];
  logic [N-1:0]   sat_pos, sat_neg;

  initial begin
    fair_ids = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
`ifdef ADD_SHARE_SAT_EN
    sat_pos = 32'h7FFF_FFFF;
    sat_neg = 32'h8000_0000;
`else
    sat_pos = 32'h8000_0000;
    sat_neg = 32'h7FFF_FFFF;
`endif
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b1;
    #2;
    chk("reset.valid", 64'(rsp_valid), 64'(0));
    chk("reset.sum",   64'(rsp_sum),   64'(0));
    chk("reset.id",    64'(rsp_id),    64'(0));
    chk("reset.ready", 64'(req_ready), 64'(0));

    // Single add on requester 0
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'b0001;
    set_req(0, 32'h5, 32'h3, 1'b0);
    #1 chk("add.ready", 64'(req_ready), 64'(4'b0001));
    @(negedge clk);
    chk_rsp("add", 32'h8, 1'b0, 1'b0, 2'd0);

    // Subtract 3-5 on requester 2 (ptr now 1)
    req_valid = 4'b0100;
    set_req(2, 32'h3, 32'h5, 1'b1);
    #1 chk("sub1.ready", 64'(req_ready), 64'(4'b0100));
    @(negedge clk);
    chk_rsp("sub1", 32'hFFFF_FFFE, 1'b0, 1'b0, 2'd2);

    // Subtract 5-3, back-to-back load while FULL with rsp_ready=1
    set_req(2, 32'h5, 32'h3, 1'b1);
    @(negedge clk);
    chk_rsp("sub2", 32'h2, 1'b1, 1'b0, 2'd2);
    req_valid = 4'b0000;
    @(negedge clk);
    chk("drain.valid", 64'(rsp_valid), 64'(0));
    chk("drain.hold",  64'(rsp_sum),   64'(32'h2));

    // Fairness: all requesters valid, ptr starts at 3
    for (int i = 0; i < 4; i++) set_req(i, 32'(i + 1), 32'h100, 1'b0);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1 chk($sformatf("fair%0d.ready", k), 64'(req_ready), 64'(4'b0001 << fair_ids[k]));
      @(negedge clk);
      chk_rsp($sformatf("fair%0d", k), 32'h101 + 32'(fair_ids[k]), 1'b0, 1'b0, fair_ids[k]);
    end

    // Backpressure: hold FULL for 3 cycles
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("bp%0d.ready", k), 64'(req_ready), 64'(0));
      @(negedge clk);
      chk_rsp($sformatf("bp%0d", k), 32'h103, 1'b0, 1'b0, 2'd2);
    end
    rsp_ready = 1'b1;
    #1 chk("bp.release.ready", 64'(req_ready), 64'(4'b1000));
    @(negedge clk);
    chk_rsp("bp.release", 32'h104, 1'b0, 1'b0, 2'd3);
    req_valid = 4'b0000;
    @(negedge clk);
    chk("bp.drain.valid", 64'(rsp_valid), 64'(0));

    // Overflow on requester 1 (ptr now 0)
    req_valid = 4'b0010;
    set_req(1, 32'h7FFF_FFFF, 32'h1, 1'b0);
    @(negedge clk);
    chk_rsp("ovf.add", sat_pos, 1'b0, 1'b1, 2'd1);
    set_req(1, 32'h8000_0000, 32'h1, 1'b1);
    @(negedge clk);
    chk_rsp("ovf.sub", sat_neg, 1'b1, 1'b1, 2'd1);

    // Reset mid-stream while FULL and stalled (ptr now 2 -> grant 3)
    req_valid = 4'b1010;
    set_req(3, 32'h10, 32'h20, 1'b0);
    @(negedge clk);
    chk_rsp("pre_rst", 32'h30, 1'b0, 1'b0, 2'd3);
    rsp_ready = 1'b0;
    rst       = 1'b1;
    #1;
    chk("rst.valid", 64'(rsp_valid), 64'(0));
    chk("rst.id",    64'(rsp_id),    64'(0));
    chk("rst.ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    #1 chk("post_rst.ready", 64'(req_ready), 64'(4'b0010));
    @(negedge clk);
    chk_rsp("post_rst", sat_neg, 1'b1, 1'b1, 2'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
